// File: rtl/vctr_fifo_strm_ops.sv
// Two-vector streaming arithmetic: two input FIFOs feed a registered operand/result pipeline
// (ADD, |a-b|, (a-b)^2, or accumulated (a-b)^2) whose results land in an output FIFO.
module vctr_fifo_strm_ops #(
  parameter int DATA_WIDTH    = 16,
  parameter int LENGTH_BITS   = 8,
  parameter int BUFFER_LENGTH = 4,
  parameter int OUT_WIDTH     = 2*DATA_WIDTH+LENGTH_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_in_v1_en,
  input  logic [DATA_WIDTH-1:0]  data_in_v1,
  output logic                   data_in_v1_full,
  input  logic                   data_in_v2_en,
  input  logic [DATA_WIDTH-1:0]  data_in_v2,
  output logic                   data_in_v2_full,
  input  logic                   data_out_en,
  output logic [OUT_WIDTH-1:0]   data_out,
  output logic                   data_out_empty,
  input  logic [LENGTH_BITS-1:0] vector_length,
  input  logic [1:0]             mode,
  input  logic                   start,
  output logic                   done,
  output logic                   idle,
  output logic                   ready,
  output logic                   overflow
);

  localparam int AW = $clog2(BUFFER_LENGTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(BUFFER_LENGTH);
  localparam logic [LENGTH_BITS-1:0] LEN_ONE = LENGTH_BITS'(1);
  localparam logic [1:0] M_ADD = 2'd0, M_ABS = 2'd1, M_SQ = 2'd2, M_ACC = 2'd3;

  // Handshake: a FIFO push/pop happens on an edge where its enable is high and the FIFO
  // can take/give a word; pushes to a full input FIFO are dropped (and flagged) unless
  // the pipeline pops that FIFO on the same edge.
  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;
  state_t state, state_nxt;

  logic [LENGTH_BITS-1:0] len, consumed, written;
  logic [1:0]             mode_q;
  logic                   acc_mode, start_acc;

  logic [DATA_WIDTH-1:0] mem1 [BUFFER_LENGTH];
  logic [DATA_WIDTH-1:0] mem2 [BUFFER_LENGTH];
  logic [OUT_WIDTH-1:0]  omem [BUFFER_LENGTH];
  logic [AW-1:0]         wp1, rp1, wp2, rp2, owp, orp;
  logic [AW:0]           cnt1, cnt2, ocnt;
  logic                  push1, push2, pop_pair, out_push, out_pop, last_write;

  logic                  op_valid, op_last, stage_valid, acc_last_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, diff;
  logic [DATA_WIDTH:0]   sum;
  logic [OUT_WIDTH-1:0]  sq, result, stage_data, acc, out_wdata;
  logic [AW+1:0]         in_flight;

  assign acc_mode  = (mode_q == M_ACC);
  assign start_acc = start && ready;

  // Elementwise results must have a reserved output slot before their operands leave the inputs.
  assign in_flight = {1'b0, ocnt} + (AW+2)'(op_valid) + (AW+2)'(stage_valid);
  assign pop_pair  = (state == S_COMPUTE) && (cnt1 != '0) && (cnt2 != '0) && (consumed < len)
                     && (acc_mode || (in_flight < {1'b0, DEPTH}));
  assign push1     = data_in_v1_en && ((cnt1 != DEPTH) || pop_pair);
  assign push2     = data_in_v2_en && ((cnt2 != DEPTH) || pop_pair);
  assign out_pop   = data_out_en && (ocnt != '0);

  assign out_push   = (state == S_COMPUTE) &&
                      (acc_mode ? (acc_last_q || (len == '0)) : stage_valid);
  assign last_write = (state == S_COMPUTE) &&
                      (acc_mode ? (acc_last_q || (len == '0))
                                : ((len == '0) || (stage_valid && (written == len - LEN_ONE))));
  assign out_wdata  = acc_mode ? acc : stage_data;

  assign data_in_v1_full = (cnt1 == DEPTH);
  assign data_in_v2_full = (cnt2 == DEPTH);
  assign data_out_empty  = (ocnt == '0);

  always_ff @(posedge clk) begin
    if (push1) mem1[wp1] <= data_in_v1;
    if (push2) mem2[wp2] <= data_in_v2;
    if (out_push) omem[owp] <= out_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp1 <= '0; rp1 <= '0; cnt1 <= '0;
      wp2 <= '0; rp2 <= '0; cnt2 <= '0;
      owp <= '0; orp <= '0; ocnt <= '0;
      data_out <= '0;
    end else begin
      if (push1)    wp1 <= wp1 + 1'b1;
      if (pop_pair) rp1 <= rp1 + 1'b1;
      cnt1 <= cnt1 + (AW+1)'(push1) - (AW+1)'(pop_pair);
      if (push2)    wp2 <= wp2 + 1'b1;
      if (pop_pair) rp2 <= rp2 + 1'b1;
      cnt2 <= cnt2 + (AW+1)'(push2) - (AW+1)'(pop_pair);
      if (out_push) owp <= owp + 1'b1;
      if (out_pop) begin
        orp      <= orp + 1'b1;
        data_out <= omem[orp];
      end
      ocnt <= ocnt + (AW+1)'(out_push) - (AW+1)'(out_pop);
    end
  end

  always_comb begin
    diff   = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
    sum    = {1'b0, a_q} + {1'b0, b_q};
    sq     = OUT_WIDTH'({{DATA_WIDTH{1'b0}}, diff} * {{DATA_WIDTH{1'b0}}, diff});
    result = sq;
    case (mode_q)
      M_ADD:   result = OUT_WIDTH'(sum);
      M_ABS:   result = OUT_WIDTH'(diff);
      default: result = sq;
    endcase
  end

  // Operand register (pop edge), then result/accumulator register one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid    <= 1'b0;
      op_last     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      acc         <= '0;
      acc_last_q  <= 1'b0;
    end else begin
      op_valid <= pop_pair;
      if (pop_pair) begin
        a_q     <= mem1[rp1];
        b_q     <= mem2[rp2];
        op_last <= (consumed == len - LEN_ONE);
      end
      stage_valid <= op_valid && !acc_mode;
      if (op_valid) stage_data <= result;
      acc_last_q  <= op_valid && acc_mode && op_last;
      if (start_acc)                 acc <= '0;
      else if (op_valid && acc_mode) acc <= acc + sq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len      <= '0;
      mode_q   <= M_ADD;
      consumed <= '0;
      written  <= '0;
      overflow <= 1'b0;
    end else begin
      if (start_acc) begin
        len      <= vector_length;
        mode_q   <= mode;
        consumed <= '0;
        written  <= '0;
      end else begin
        if (pop_pair) consumed <= consumed + LEN_ONE;
        if (out_push) written  <= written + LEN_ONE;
      end
      // A drop on the start edge still counts against the new run.
      if ((data_in_v1_en && !push1) || (data_in_v2_en && !push2)) overflow <= 1'b1;
      else if (start_acc)                                          overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_acc) state_nxt = S_COMPUTE;
      S_COMPUTE: if (last_write) state_nxt = S_DONE;
      S_DONE:    if ((ocnt == '0) && !out_pop) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idle  = (state == S_IDLE);
    ready = (state == S_IDLE);
    done  = (state == S_DONE);
  end

endmodule

// File: tb/tb_vctr_fifo_strm_ops.sv
// Directed and randomized runs of vctr_fifo_strm_ops checked against a queue-based model.
`timescale 1ns/1ps
module tb_vctr_fifo_strm_ops;

  localparam int DW = 16;
  localparam int LB = 8;
  localparam int BL = 4;
  localparam int OW = 2*DW+LB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_in_v1_en = 1'b0, data_in_v2_en = 1'b0;
  logic [DW-1:0] data_in_v1 = '0, data_in_v2 = '0;
  logic          data_in_v1_full, data_in_v2_full;
  logic          data_out_en = 1'b0;
  logic [OW-1:0] data_out;
  logic          data_out_empty;
  logic [LB-1:0] vector_length = '0;
  logic [1:0]    mode = '0;
  logic          start = 1'b0;
  logic          done, idle, ready, overflow;

  vctr_fifo_strm_ops #(.DATA_WIDTH(DW), .LENGTH_BITS(LB), .BUFFER_LENGTH(BL), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_v1_en(data_in_v1_en), .data_in_v1(data_in_v1), .data_in_v1_full(data_in_v1_full),
    .data_in_v2_en(data_in_v2_en), .data_in_v2(data_in_v2), .data_in_v2_full(data_in_v2_full),
    .data_out_en(data_out_en), .data_out(data_out), .data_out_empty(data_out_empty),
    .vector_length(vector_length), .mode(mode), .start(start),
    .done(done), .idle(idle), .ready(ready), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [OW-1:0] exp_q[$];
  logic [DW-1:0] va[$], vb[$];
  bit drain_en = 1'b0;
  bit pend = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard: pops whenever allowed and compares each popped word with the model queue
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      data_out_en = 1'b0;
    end else begin
      if (pend) begin
        chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) chk("data_out", 64'(data_out), 64'(exp_q.pop_front()));
        n_out++;
      end
      data_out_en = drain_en && !data_out_empty;
      pend = data_out_en;
    end
  end

  // reference model: results straight from the mode definitions, in integer arithmetic
  function automatic void model(input int m, input int len);
    longint acc = 0;
    for (int i = 0; i < len; i++) begin
      longint a = longint'(va[i]);
      longint b = longint'(vb[i]);
      longint d = (a > b) ? a - b : b - a;
      case (m)
        0: exp_q.push_back(OW'(a + b));
        1: exp_q.push_back(OW'(d));
        2: exp_q.push_back(OW'(d * d));
        default: acc += d * d;
      endcase
    end
    if (m == 3) exp_q.push_back(OW'(acc));
  endfunction

  // drivers
  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int c = 0;
    while ((data_in_v1_full || data_in_v2_full) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("push_wait", 64'(c < 200), 64'(1));
    data_in_v1_en = 1'b1; data_in_v1 = a;
    data_in_v2_en = 1'b1; data_in_v2 = b;
    @(negedge clk);
    data_in_v1_en = 1'b0;
    data_in_v2_en = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input int len);
    chk("ready_before_start", 64'(ready), 64'(1));
    mode = m;
    vector_length = LB'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_reached", 64'(done), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (!idle && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("idle_reached", 64'(idle), 64'(1));
  endtask

  task automatic run_vec(input logic [1:0] m, input int len);
    model(m, len);
    drain_en = 1'b1;
    do_start(m, len);
    for (int i = 0; i < len; i++) push_pair(va[i], vb[i]);
    wait_done(500);
    wait_idle(500);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("overflow_clear", 64'(overflow), 64'(0));
  endtask

  task automatic load(input logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    va = '{a0, a1, a2, a3};
    vb = '{b0, b1, b2, b3};
  endtask

  initial begin
    int c, n0;
    logic [1:0] rm;
    int rl;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_data_out", 64'(data_out), 64'(0));
    chk("rst_out_empty", 64'(data_out_empty), 64'(1));
    chk("rst_full1", 64'(data_in_v1_full), 64'(0));
    chk("rst_full2", 64'(data_in_v2_full), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // ADD len=8: 1..8 + 9..16
    va.delete(); vb.delete();
    for (int i = 1; i <= 8; i++) begin va.push_back(DW'(i)); vb.push_back(DW'(i + 8)); end
    n0 = n_out;
    run_vec(2'd0, 8);
    chk("add_count", 64'(n_out - n0), 64'(8));

    // SQ_DIFF preloaded: first result visible three edges after the start edge
    load(16'd10, 16'd3, 16'hFFFF, 16'd7, 16'd4, 16'd8, 16'd0, 16'd7);
    model(2, 4);
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push_pair(va[i], vb[i]);
    chk("preload_full1", 64'(data_in_v1_full), 64'(1));
    do_start(2'd2, 4);
    c = 1;
    while (data_out_empty && c < 20) begin @(negedge clk); c++; end
    chk("sq_latency", 64'(c), 64'(4));
    drain_en = 1'b1;
    wait_done(200);
    wait_idle(200);
    chk("sq_drained", 64'(exp_q.size()), 64'(0));
    chk("sq_overflow", 64'(overflow), 64'(0));

    // ACC_SQ_DIFF: four pops, then the sum is written two edges after the last pop
    model(3, 4);
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push_pair(va[i], vb[i]);
    n0 = n_out;
    do_start(2'd3, 4);
    c = 1;
    while (!done && c < 30) begin @(negedge clk); c++; end
    chk("acc_done_latency", 64'(c), 64'(7));
    drain_en = 1'b1;
    wait_idle(200);
    chk("acc_count", 64'(n_out - n0), 64'(1));
    chk("acc_drained", 64'(exp_q.size()), 64'(0));

    // len=0 ADD: COMPUTE for one edge, then DONE, then IDLE, no output
    n0 = n_out;
    do_start(2'd0, 0);
    chk("len0_compute_done", 64'(done), 64'(0));
    chk("len0_compute_idle", 64'(idle), 64'(0));
    @(negedge clk);
    chk("len0_done", 64'(done), 64'(1));
    @(negedge clk);
    chk("len0_idle", 64'(idle), 64'(1));
    chk("len0_no_output", 64'(n_out - n0), 64'(0));

    // len=0 ACC: exactly one zero word
    n0 = n_out;
    run_vec(2'd3, 0);
    chk("len0_acc_count", 64'(n_out - n0), 64'(1));

    // backpressure: ABS_DIFF len=8 with output not drained
    va.delete(); vb.delete();
    for (int i = 0; i < 8; i++) begin
      va.push_back(DW'($urandom_range(0, 65535)));
      vb.push_back(DW'($urandom_range(0, 65535)));
    end
    model(1, 8);
    drain_en = 1'b0;
    do_start(2'd1, 8);
    for (int i = 0; i < 8; i++) push_pair(va[i], vb[i]);
    repeat (6) @(negedge clk);
    chk("bp_full1", 64'(data_in_v1_full), 64'(1));
    chk("bp_full2", 64'(data_in_v2_full), 64'(1));
    chk("bp_out_nonempty", 64'(data_out_empty), 64'(0));
    chk("bp_not_done", 64'(done), 64'(0));
    chk("bp_no_overflow_yet", 64'(overflow), 64'(0));
    data_in_v1_en = 1'b1; data_in_v1 = 16'h1234;
    data_in_v2_en = 1'b1; data_in_v2 = 16'h4321;
    @(negedge clk);
    data_in_v1_en = 1'b0; data_in_v2_en = 1'b0;
    chk("bp_overflow_set", 64'(overflow), 64'(1));
    drain_en = 1'b1;
    wait_done(300);
    wait_idle(300);
    chk("bp_drained", 64'(exp_q.size()), 64'(0));
    chk("bp_overflow_sticky", 64'(overflow), 64'(1));

    // randomized runs (the first also shows overflow cleared by start)
    for (int r = 0; r < 6; r++) begin
      rm = 2'($urandom_range(0, 3));
      rl = $urandom_range(1, 12);
      va.delete(); vb.delete();
      for (int i = 0; i < rl; i++) begin
        va.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : DW'($urandom_range(0, 65535)));
        vb.push_back(($urandom_range(0, 3) == 0) ? 16'h0000 : DW'($urandom_range(0, 65535)));
      end
      run_vec(rm, rl);
    end

    // reset in the middle of a run
    va.delete(); vb.delete();
    for (int i = 0; i < 3; i++) begin
      va.push_back(DW'($urandom_range(1, 65535)));
      vb.push_back(DW'($urandom_range(1, 65535)));
    end
    model(0, 3);
    drain_en = 1'b1;
    for (int i = 0; i < 3; i++) push_pair(va[i], vb[i]);
    do_start(2'd0, 8);
    repeat (6) @(negedge clk);
    chk("mid_busy", 64'(idle), 64'(0));
    drain_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data_out", 64'(data_out), 64'(0));
    chk("mid_rst_out_empty", 64'(data_out_empty), 64'(1));
    chk("mid_rst_idle", 64'(idle), 64'(1));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_full1", 64'(data_in_v1_full), 64'(0));
    chk("mid_rst_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    va = '{16'd1, 16'd2};
    vb = '{16'd3, 16'd4};
    n0 = n_out;
    run_vec(2'd0, 2);
    chk("post_rst_count", 64'(n_out - n0), 64'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
